mesh_packet_tx: RTL and testbench

//  Injection-side network adapter for the 2D mesh. Turns a word stream (dest + payload words) from a

---
 rtl/mesh_packet_tx.sv | 212 +++++++++++++++++++++
 tb/tb_mesh_packet_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_packet_tx.sv
// -----------------------------------------------------------------------------
// mesh_packet_tx
//   Injection-side network adapter for the 2D mesh. It accepts a word stream
//   from a tile (destination, priority and VC are sampled with the first word)
//   and emits a flit packet on a router local input port. Every packet is a
//   HEADER flit, then payload flits, and it ends with a LAST flit. Messages
//   longer than max_payload words are split into several packets. Each packet
//   after the first repeats the header. Messages whose destination is out of
//   range are consumed and dropped, and err_o pulses once for each of them.
//
// Handshake: a word moves on in_valid && in_ready. A flit moves on any VC
//   where out_valid[vc] && out_ready[vc]. Once out_valid is raised, the flit
//   and its VC are held until they are taken.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   in_valid    word valid
//   in_ready    word accepted when in_valid && in_ready
//   in_data     payload word
//   in_last     final word of the message
//   in_dest     destination node (sampled with the first word)
//   in_prio     priority (sampled with in_dest)
//   in_vc       virtual channel (sampled with in_dest)
//   out_flit    {type, data} flit to the router
//   out_valid   one-hot valid on the selected VC
//   out_ready   router ready, one bit per VC
//   err_o       1-cycle pulse when a message is dropped
//   dbg_state   current FSM state (IDLE=0, PAY=1, REHDR=2, DROP=3)
// -----------------------------------------------------------------------------
module mesh_packet_tx #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 1,
  parameter int num_dests       = 4,
  parameter int ph_dest_width   = 2,
  parameter int ph_prio_width   = 4,
  parameter int max_payload     = 6,
  localparam int flit_width     = flit_type_width + flit_data_width,
  localparam int vc_width       = (vchannels > 1) ? $clog2(vchannels) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [flit_data_width-1:0] in_data,
  input  logic                       in_last,
  input  logic [ph_dest_width-1:0]   in_dest,
  input  logic [ph_prio_width-1:0]   in_prio,
  input  logic [vc_width-1:0]        in_vc,
  output logic [flit_width-1:0]      out_flit,
  output logic [vchannels-1:0]       out_valid,
  input  logic [vchannels-1:0]       out_ready,
  output logic                       err_o,
  output logic [1:0]                 dbg_state
);

  localparam int cnt_width = $clog2(max_payload + 1);
  localparam logic [cnt_width-1:0] last_cnt = cnt_width'(max_payload - 1);

  localparam logic [flit_type_width-1:0] type_payload = flit_type_width'(0);
  localparam logic [flit_type_width-1:0] type_header  = flit_type_width'(1);
  localparam logic [flit_type_width-1:0] type_last    = flit_type_width'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAY   = 2'd1,
    REHDR = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t state, state_n;

  // Output register
  logic                  ovalid;
  logic [flit_width-1:0] oflit;
  logic [vc_width-1:0]   vc_q;

  // Packet context, kept so that the header can be repeated for each packet
  logic [ph_dest_width-1:0] dest_q;
  logic [ph_prio_width-1:0] prio_q;
  logic [vc_width-1:0]      vc_lat;
  logic [cnt_width-1:0]     cnt, cnt_n;
  logic                     err_q;

  // Control signals from the next-state logic
  logic                  load;
  logic [flit_width-1:0] load_flit;
  logic [vc_width-1:0]   load_vc;
  logic                  latch;
  logic                  err_set;
  logic                  in_ready_c;

  logic xfer;
  logic space;
  logic dest_ok;

  function automatic logic [flit_width-1:0] make_hdr(
    input logic [ph_dest_width-1:0] d,
    input logic [ph_prio_width-1:0] p
  );
    logic [flit_data_width-1:0] data;
    data = '0;
    data[flit_data_width-1 -: ph_dest_width] = d;
    data[flit_data_width-1-ph_dest_width -: ph_prio_width] = p;
    return {type_header, data};
  endfunction

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < vchannels; i++) begin
      out_valid[i] = ovalid && (vc_q == vc_width'(i));
    end
  end

  assign xfer      = |(out_valid & out_ready);
  // The register can take a new flit if it is empty or is being emptied now
  assign space     = !ovalid || xfer;
  assign dest_ok   = (32'(in_dest) < 32'(num_dests));
  assign out_flit  = oflit;
  assign err_o     = err_q;
  assign dbg_state = state;
  // Words are never accepted while reset is asserted
  assign in_ready  = in_ready_c && !rst;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    load       = 1'b0;
    load_flit  = '0;
    load_vc    = vc_lat;
    latch      = 1'b0;
    err_set    = 1'b0;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        // The first word is only looked at here. PAY or DROP consumes it.
        if (in_valid) begin
          if (!dest_ok) begin
            err_set = 1'b1;
            state_n = DROP;
          end else if (space) begin
            latch     = 1'b1;
            load      = 1'b1;
            load_flit = make_hdr(in_dest, in_prio);
            load_vc   = in_vc;
            cnt_n     = '0;
            state_n   = PAY;
          end
        end
      end
      PAY: begin
        in_ready_c = space;
        if (in_valid && space) begin
          load      = 1'b1;
          load_flit = {(in_last || cnt == last_cnt) ? type_last : type_payload, in_data};
          cnt_n     = cnt + 1'b1;
          if (in_last) begin
            state_n = IDLE;
          end else if (cnt == last_cnt) begin
            state_n = REHDR;
          end
        end
      end
      REHDR: begin
        if (space) begin
          load      = 1'b1;
          load_flit = make_hdr(dest_q, prio_q);
          cnt_n     = '0;
          state_n   = PAY;
        end
      end
      DROP: begin
        in_ready_c = 1'b1;
        if (in_valid && in_last) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ovalid <= 1'b0;
      oflit  <= '0;
      vc_q   <= '0;
      dest_q <= '0;
      prio_q <= '0;
      vc_lat <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= err_set;
      if (latch) begin
        dest_q <= in_dest;
        prio_q <= in_prio;
        vc_lat <= in_vc;
      end
      if (load) begin
        ovalid <= 1'b1;
        oflit  <= load_flit;
        vc_q   <= load_vc;
      end else if (xfer) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mesh_packet_tx.sv
// -----------------------------------------------------------------------------
// tb_mesh_packet_tx
//   Directed bench for mesh_packet_tx with 2 VCs and 3-bit destination fields,
//   so that an out-of-range destination (4) can be driven. Inputs change on the
//   falling edge. The monitor samples 3 ns after the falling edge, so every
//   value it reads is the one the next rising edge will act on.
// -----------------------------------------------------------------------------
module tb_mesh_packet_tx;
  localparam int FDW = 32;
  localparam int VCH = 2;
  localparam int ND  = 4;
  localparam int DW  = 3;
  localparam int PW  = 4;
  localparam int MP  = 6;
  localparam int FW  = FDW + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [FDW-1:0] in_data;
  logic           in_last;
  logic [DW-1:0]  in_dest;
  logic [PW-1:0]  in_prio;
  logic [0:0]     in_vc;
  logic [FW-1:0]  out_flit;
  logic [VCH-1:0] out_valid;
  logic [VCH-1:0] out_ready;
  logic           err_o;
  logic [1:0]     dbg_state;

  mesh_packet_tx #(
    .flit_data_width(FDW), .flit_type_width(2), .vchannels(VCH), .num_dests(ND),
    .ph_dest_width(DW), .ph_prio_width(PW), .max_payload(MP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_dest(in_dest), .in_prio(in_prio), .in_vc(in_vc),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready), .err_o(err_o),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [VCH+FW-1:0] exp_q[$];
  int                xfer_cyc_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                exp_err  = 0;
  int                err_seen = 0;

  function automatic logic [FDW-1:0] hdr(input logic [DW-1:0] d, input logic [PW-1:0] p);
    return {d, p, 25'd0};
  endfunction

  task automatic push_exp(input logic vc, input logic [1:0] t, input logic [FDW-1:0] d);
    exp_q.push_back({(vc ? 2'b10 : 2'b01), t, d});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- monitor ----------------
  logic              prev_pend = 1'b0;
  logic [FW-1:0]     prev_flit;
  logic [VCH-1:0]    prev_valid;
  logic [VCH+FW-1:0] e;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        n_checks++;
        if (out_flit !== prev_flit || out_valid !== prev_valid) begin
          n_errors++;
          $display("FAIL stall_hold: got %0h/%0b expected %0h/%0b", out_flit, out_valid,
                   prev_flit, prev_valid);
        end
      end
      if (out_valid != '0) begin
        n_checks++;
        if (!$onehot(out_valid)) begin
          n_errors++;
          $display("FAIL onehot: out_valid=%0b", out_valid);
        end
      end
      if (err_o) err_seen++;
      if (|(out_valid & out_ready)) begin
        xfer_cyc_q.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_flit: got %0b/%0h expected none", out_valid, out_flit);
        end else begin
          e = exp_q.pop_front();
          if ({out_valid, out_flit} !== e) begin
            n_errors++;
            $display("FAIL flit: got %0b/%0h expected %0b/%0h", out_valid, out_flit,
                     e[VCH+FW-1 -: VCH], e[FW-1:0]);
          end
        end
      end
      prev_pend  = (out_valid != '0) && !(|(out_valid & out_ready));
      prev_flit  = out_flit;
      prev_valid = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [FDW-1:0] d, input logic last, input logic [DW-1:0] dest,
                           input logic [PW-1:0] prio, input logic vc);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_dest  = dest;
    in_prio  = prio;
    in_vc    = vc;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL word_timeout: got in_ready=0 expected 1 for word %0h", d);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Pushes the flits a message should produce, then drives its words
  task automatic send_msg(input logic [DW-1:0] dest, input logic [PW-1:0] prio, input logic vc,
                          input int n, input logic [FDW-1:0] base);
    int cnt;
    if (dest < ND) begin
      push_exp(vc, 2'b01, hdr(dest, prio));
      cnt = 0;
      for (int i = 0; i < n; i++) begin
        push_exp(vc, (i == n - 1 || cnt == MP - 1) ? 2'b10 : 2'b00, base + FDW'(i));
        cnt++;
        if (i != n - 1 && cnt == MP) begin
          push_exp(vc, 2'b01, hdr(dest, prio));
          cnt = 0;
        end
      end
    end else begin
      exp_err++;
    end
    for (int i = 0; i < n; i++) begin
      send_word(base + FDW'(i), (i == n - 1), dest, prio, vc);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_dest   = '0;
    in_prio   = '0;
    in_vc     = '0;
    out_ready = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);

    // 1: two-word message, hand-computed flits, back to back
    xfer_cyc_q.delete();
    exp_q.push_back({2'b01, 2'b01, 32'h6A00_0000});
    exp_q.push_back({2'b01, 2'b00, 32'hAAAA_0001});
    exp_q.push_back({2'b01, 2'b10, 32'hBBBB_0002});
    send_word(32'hAAAA_0001, 1'b0, 3'd3, 4'd5, 1'b0);
    send_word(32'hBBBB_0002, 1'b1, 3'd3, 4'd5, 1'b0);
    drain();
    #1;
    chk("t1_nflits", 64'(xfer_cyc_q.size()), 64'd3);
    if (xfer_cyc_q.size() == 3) chk("t1_consecutive", 64'(xfer_cyc_q[2] - xfer_cyc_q[0]), 64'd2);
    chk("t1_idle_after", 64'(out_valid), 64'd0);

    // 2: 8 words split into 6 + 2
    send_msg(3'd1, 4'd7, 1'b0, 8, 32'h2000_0000);
    drain();

    // 3: one-word message followed immediately by a second message
    xfer_cyc_q.delete();
    send_msg(3'd2, 4'd3, 1'b1, 1, 32'h3000_0000);
    send_msg(3'd0, 4'd1, 1'b0, 2, 32'h3100_0000);
    drain();
    chk("t3_nflits", 64'(xfer_cyc_q.size()), 64'd5);
    if (xfer_cyc_q.size() == 5) chk("t3_no_bubble", 64'(xfer_cyc_q[4] - xfer_cyc_q[0]), 64'd4);

    // 4: stall the router for 3 cycles while a payload flit waits
    fork
      send_msg(3'd1, 4'd2, 1'b0, 4, 32'h4000_0000);
      begin
        repeat (2) @(negedge clk);
        out_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("t4_stall_in_ready", 64'(in_ready), 64'd0);
          @(negedge clk);
        end
        out_ready = 2'b11;
      end
    join
    drain();

    // 5: out-of-range destination is dropped, then a normal message
    send_msg(3'd4, 4'd0, 1'b0, 3, 32'h5000_0000);
    send_msg(3'd3, 4'd15, 1'b1, 2, 32'h5100_0000);
    drain();

    // exact multiple of max_payload: no trailing empty packet
    send_msg(3'd0, 4'd4, 1'b1, 12, 32'h5200_0000);
    drain();

    // 6: reset after the second payload flit, then a message on VC 1
    push_exp(1'b1, 2'b01, hdr(3'd2, 4'd9));
    push_exp(1'b1, 2'b00, 32'h6000_0000);
    push_exp(1'b1, 2'b00, 32'h6000_0001);
    in_valid = 1'b1; in_last = 1'b0; in_dest = 3'd2; in_prio = 4'd9; in_vc = 1'b1;
    in_data  = 32'h6000_0000;
    @(negedge clk);
    @(negedge clk);
    in_data = 32'h6000_0001;
    @(negedge clk);
    in_data = 32'h6000_0002;
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 2'b00;
    in_valid  = 1'b0;
    #1;
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 2'b11;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_state", 64'(dbg_state), 64'd0);
    chk("t6_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    send_msg(3'd2, 4'd9, 1'b1, 3, 32'h6100_0000);
    drain();

    chk("final_queue", 64'(exp_q.size()), 64'd0);
    chk("err_pulses", 64'(err_seen), 64'(exp_err));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
